rr_mux: RTL and testbench
=========================

RR_MUX -- requirements
Module: rr_mux

Interface
REQ-001 Parameter WL, default 32, data word width in bits.
REQ-002 Parameter N, default 4, number of input channels (N >= 1).
REQ-003 Parameter SW, default max(1, clog2(N)), channel-index width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 mode  input  1  arbitration mode: 0 = round-robin, 1 = fixed priority (lowest index wins).
REQ-007 in_valid  input  N  per-channel request; bit i = channel i.
REQ-008 in_data  input  N*WL  packed channel words; channel i occupies bits [i*WL +: WL].
REQ-009 in_ready  output  N  per-channel accept; combinational, one-hot or zero.
REQ-010 out_valid  output  1  output register holds a word.
REQ-011 out_data  output  WL  registered selected word.
REQ-012 out_sel  output  SW  registered index of the channel that supplied out_data.
REQ-013 out_ready  input  1  downstream accept.

Function
REQ-014 Handshake: a transfer occurs on a port when valid and ready are both 1 at a rising edge.
REQ-015 load = !out_valid | out_ready; arbitration is enabled only when load = 1.
REQ-016 in_ready[i] = 1 only when load = 1, in_valid[i] = 1, and channel i is the grant winner; at most one bit set.
REQ-017 Round-robin winner: first valid channel scanning ptr+1, ptr+2, ..., wrapping modulo N, ending at ptr.
REQ-018 Fixed-priority winner: lowest-index valid channel; ptr is ignored for selection.
REQ-019 On a transfer from channel g: out_data <= in_data[g], out_sel <= g, out_valid <= 1, ptr <= g (both modes).
REQ-020 Latency: one cycle from accepted input to out_valid = 1.
REQ-021 Throughput: one word per cycle when out_ready = 1 continuously; a simultaneous drain and load in the same edge is required.
REQ-022 load = 1 with no in_valid bit set: out_valid <= 0; out_data, out_sel and ptr hold.
REQ-023 Backpressure: while out_valid = 1 and out_ready = 0, out_data, out_sel, out_valid and ptr hold; all in_ready = 0.
REQ-024 in_valid deasserting without a transfer is legal and leaves no state change.
REQ-025 A mode change takes effect on the next arbitration; ptr is not reset by it.
REQ-026 N = 1: channel 0 always wins when valid; out_sel is constant 0.
REQ-027 Round-robin fairness: with all N channels valid and out_ready = 1, every channel is granted exactly once in any N consecutive transfers.

Reset
REQ-028 While rst_n = 0: out_valid = 0, out_data = 0, out_sel = 0, ptr = N-1, so channel 0 has first round-robin priority.
REQ-029 Reset asserted mid-transfer discards the held word immediately, without waiting for a clock edge.
REQ-030 in_ready is 0 while rst_n = 0.

Structure
REQ-031 Shared package mux_pkg holds the clog2 helper and the constants MODE_RR = 0 and MODE_FIXED = 1.
REQ-032 Arbitration is split into one sub-module, rr_arbiter (N, mode, req, ptr -> one-hot grant plus index); rr_mux holds the output register and ptr.

Verification
REQ-033 Reset check: rst_n = 0 with in_valid = 4'b1111 -> out_valid = 0, out_data = 0, in_ready = 0.
REQ-034 Round-robin, all valid: N = 4, mode = 0, in_valid = 4'b1111, out_ready = 1, channel data 0xA0..0xA3 -> out_sel sequence 0,1,2,3,0; out_data 0xA0,0xA1,0xA2,0xA3,0xA0 on consecutive cycles.
REQ-035 Fixed priority: mode = 1, in_valid = 4'b1010, out_ready = 1 -> out_sel = 1 every cycle; in_ready = 4'b0010.
REQ-036 Backpressure: out_valid = 1, out_sel = 2, out_ready = 0 for 3 cycles -> outputs stable and in_ready = 0 throughout; out_ready = 1 -> next word loads on that edge.
REQ-037 Wrap and skip: ptr = 3 with in_valid = 4'b0100 -> grant channel 2; then in_valid = 4'b0101 -> grant channel 0.
REQ-038 Asynchronous reset: rst_n pulled low between edges while out_valid = 1 -> out_valid = 0 immediately; after release, channel 0 wins first.

Source files
------------

// File: rtl/mux_pkg.sv
// mux_pkg: shared constants and helpers for the round-robin mux slice.
// Provides the clog2 helper and the arbitration mode encodings.
package mux_pkg;

    localparam logic MODE_RR    = 1'b0;
    localparam logic MODE_FIXED = 1'b1;

    // Ceiling log2; returns 0 for n <= 1.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational N-way arbiter, round-robin or fixed priority.
// Ports: mode, req[N], ptr[SW] in; one-hot grant[N], grant_idx[SW], grant_any out.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int N  = 4,
    parameter int SW = (clog2(N) > 1) ? clog2(N) : 1
) (
    input  logic          mode,
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [SW-1:0] grant_idx,
    output logic          grant_any
);

    always_comb begin
        int idx;
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        idx       = 0;
        if (mode == MODE_FIXED) begin
            for (int i = 0; i < N; i++) begin
                if (req[i] && !grant_any) begin
                    grant_any = 1'b1;
                    grant_idx = SW'(i);
                end
            end
        end else begin
            // Scan ptr+1 .. ptr+N so the last winner has lowest priority.
            for (int k = 1; k <= N; k++) begin
                idx = (int'(ptr) + k) % N;
                if (req[idx] && !grant_any) begin
                    grant_any = 1'b1;
                    grant_idx = SW'(idx);
                end
            end
        end
        if (grant_any) grant[grant_idx] = 1'b1;
    end

endmodule

// File: rtl/rr_mux.sv
// rr_mux: N-channel arbitrated mux with a registered valid/ready output.
// Ports: clk, rst_n, mode, in_valid/in_data/in_ready, out_valid/out_data/out_sel/out_ready.
module rr_mux
    import mux_pkg::*;
#(
    parameter int WL = 32,
    parameter int N  = 4,
    parameter int SW = (clog2(N) > 1) ? clog2(N) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            mode,
    input  logic [N-1:0]    in_valid,
    input  logic [N*WL-1:0] in_data,
    output logic [N-1:0]    in_ready,
    output logic            out_valid,
    output logic [WL-1:0]   out_data,
    output logic [SW-1:0]   out_sel,
    input  logic            out_ready
);

    logic          out_valid_q, out_valid_d;
    logic [WL-1:0] out_data_q, out_data_d;
    logic [SW-1:0] out_sel_q, out_sel_d;
    logic [SW-1:0] ptr_q, ptr_d;

    logic [N-1:0]  grant;
    logic [SW-1:0] grant_idx;
    logic          grant_any;
    logic          load;

    rr_arbiter #(.N(N), .SW(SW)) u_arb (
        .mode      (mode),
        .req       (in_valid),
        .ptr       (ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    // Output slot is free when empty or being drained this edge.
    assign load = !out_valid_q || out_ready;

    // rst_n gates in_ready so no handshake is advertised during reset.
    assign in_ready = (load && rst_n) ? grant : '0;

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        ptr_d       = ptr_q;
        if (load) begin
            if (grant_any) begin
                out_valid_d = 1'b1;
                out_data_d  = in_data[int'(grant_idx)*WL +: WL];
                out_sel_d   = grant_idx;
                ptr_d       = grant_idx;
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            ptr_q       <= SW'(N - 1);
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_rr_mux.sv
// tb_rr_mux: directed and random checks of rr_mux against a behavioural model.
// Drives N=4, WL=32; compares in_ready before each edge and outputs after it.
module tb_rr_mux;

    localparam int WL = 32;
    localparam int N  = 4;
    localparam int SW = 2;

    logic            clk;
    logic            rst_n;
    logic            mode;
    logic [N-1:0]    in_valid;
    logic [N*WL-1:0] in_data;
    logic [N-1:0]    in_ready;
    logic            out_valid;
    logic [WL-1:0]   out_data;
    logic [SW-1:0]   out_sel;
    logic            out_ready;

    int tests;
    int failed;

    // Reference model state
    bit        m_valid;
    bit [31:0] m_data;
    int        m_sel;
    int        m_ptr;

    rr_mux #(.WL(WL), .N(N), .SW(SW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int winner();
        if (mode) begin
            for (int i = 0; i < N; i++)
                if (in_valid[i]) return i;
        end else begin
            for (int k = 1; k <= N; k++)
                if (in_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] exp_ready();
        int w;
        w = winner();
        if (!rst_n) return '0;
        if ((!m_valid || out_ready) && w >= 0) return N'(1 << w);
        return '0;
    endfunction

    task automatic model_reset();
        m_valid = 0;
        m_data  = 0;
        m_sel   = 0;
        m_ptr   = N - 1;
    endtask

    task automatic set_data(input bit [31:0] base);
        for (int i = 0; i < N; i++) in_data[i*WL +: WL] = base + 32'(i);
    endtask

    // One clock: check in_ready, take the edge, update model, check outputs.
    task automatic cycle();
        int w;
        #1;
        chk("in_ready", 64'(in_ready), 64'(exp_ready()));
        w = winner();
        @(posedge clk);
        if (!m_valid || out_ready) begin
            if (w >= 0) begin
                m_valid = 1;
                m_data  = in_data[w*WL +: WL];
                m_sel   = w;
                m_ptr   = w;
            end else begin
                m_valid = 0;
            end
        end
        #1;
        chk("out_valid", 64'(out_valid), 64'(m_valid));
        chk("out_data", 64'(out_data), 64'(m_data));
        chk("out_sel", 64'(out_sel), 64'(m_sel));
    endtask

    initial begin
        tests     = 0;
        failed    = 0;
        rst_n     = 1'b0;
        mode      = 1'b0;
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        set_data(32'hA0);
        model_reset();

        // Reset state
        repeat (2) @(posedge clk);
        #2;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_sel", 64'(out_sel), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Round-robin with all channels requesting
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("rr_seq_sel", 64'(out_sel), 64'(i % 4));
            chk("rr_seq_data", 64'(out_data), 64'(32'hA0 + 32'(i % 4)));
        end

        // Park ptr on 3, then wrap-and-skip
        in_valid = 4'b1000;
        cycle();
        in_valid = 4'b0100;
        cycle();
        chk("wrap_sel2", 64'(out_sel), 64'd2);
        in_valid = 4'b0101;
        cycle();
        chk("skip_sel0", 64'(out_sel), 64'd0);

        // Fixed priority
        mode     = 1'b1;
        in_valid = 4'b1010;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("fix_ready", 64'(in_ready), 64'b0010);
            cycle();
            chk("fix_sel", 64'(out_sel), 64'd1);
        end

        // Backpressure holding channel 2
        mode     = 1'b0;
        in_valid = 4'b0100;
        cycle();
        chk("bp_sel", 64'(out_sel), 64'd2);
        set_data(32'hB0);
        out_ready = 1'b0;
        in_valid  = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("bp_hold_ready", 64'(in_ready), 64'd0);
            chk("bp_hold_sel", 64'(out_sel), 64'd2);
            chk("bp_hold_data", 64'(out_data), 64'(32'hA2));
        end
        out_ready = 1'b1;
        cycle();
        chk("bp_release_sel", 64'(out_sel), 64'd3);
        chk("bp_release_data", 64'(out_data), 64'(32'hB3));

        // No request drains the slot, data holds
        in_valid = 4'b0000;
        cycle();
        chk("idle_valid", 64'(out_valid), 64'd0);

        // Asynchronous reset between edges
        in_valid = 4'b0010;
        cycle();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("arst_valid", 64'(out_valid), 64'd0);
        chk("arst_data", 64'(out_data), 64'd0);
        chk("arst_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 4'b1111;
        cycle();
        chk("arst_first_sel", 64'(out_sel), 64'd0);

        // Random traffic against the model
        for (int i = 0; i < 300; i++) begin
            mode      = ($urandom_range(0, 3) == 0);
            in_valid  = 4'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            for (int c = 0; c < N; c++) in_data[c*WL +: WL] = $urandom;
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule
